// File: rtl/pipa_axis_sync_if.sv
// Per-axis PIPA bundle: raw IMU pulses and control strobes in, counter requests
// and window classification out.
interface pipa_axis_sync_if;
  logic PIPGp;
  logic PIPGm;
  logic F5ASB2;
  logic CNTACK;
  logic GOJAM;
  logic CCH33;
  logic PIPP;
  logic PIPM;
  logic NOP;
  logic NOM;
  logic BOTH;
  logic MISS;
  logic PIPAFL;
  logic PIPOVF;

  modport master (
    output PIPGp, PIPGm, F5ASB2, CNTACK, GOJAM, CCH33,
    input  PIPP, PIPM, NOP, NOM, BOTH, MISS, PIPAFL, PIPOVF
  );

  modport slave (
    input  PIPGp, PIPGm, F5ASB2, CNTACK, GOJAM, CCH33,
    output PIPP, PIPM, NOP, NOM, BOTH, MISS, PIPAFL, PIPOVF
  );
endinterface

// File: rtl/pipa_axis_sync.sv
// Single-axis PIPA pulse conditioner: synchronises plus/minus pulse trains, classifies
// each F5ASB2 window, queues counter requests and raises sticky fail/overflow alarms.
module pipa_axis_sync #(
  parameter int FAIL_LIMIT = 4,
  parameter int PEND_W     = 2
) (
  input  logic             CLOCK,
  input  logic             rst,
  pipa_axis_sync_if.slave  bus
);

  localparam logic [3:0]        FAIL_LIM = 4'(FAIL_LIMIT);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic              p_s1_q, p_s2_q, p_prev_q;
  logic              m_s1_q, m_s2_q, m_prev_q;
  logic              seen_p_q, seen_p_d, seen_m_q, seen_m_d;
  logic              nop_q, nop_d, nom_q, nom_d, both_q, both_d, miss_q, miss_d;
  logic [PEND_W-1:0] pend_p_q, pend_p_d, pend_m_q, pend_m_d;
  logic [3:0]        fail_q, fail_d;
  logic              afl_q, afl_d, ovf_q, ovf_d;

  logic edge_p, edge_m, win_p, win_m;
  logic strobe, ack_p, ack_m, enq_p, enq_m;

  always_comb begin
    edge_p = p_s2_q & ~p_prev_q;
    edge_m = m_s2_q & ~m_prev_q;
    win_p  = seen_p_q | edge_p;
    win_m  = seen_m_q | edge_m;
    // GOJAM swallows any coincident strobe or acknowledge
    strobe = bus.F5ASB2 & ~bus.GOJAM;
    ack_p  = bus.CNTACK & ~bus.GOJAM & (pend_p_q != '0);
    ack_m  = bus.CNTACK & ~bus.GOJAM & (pend_p_q == '0) & (pend_m_q != '0);
    enq_p  = strobe & win_p & ~win_m;
    enq_m  = strobe & win_m & ~win_p;

    seen_p_d = win_p;
    seen_m_d = win_m;
    nop_d    = nop_q;
    nom_d    = nom_q;
    both_d   = both_q;
    miss_d   = miss_q;
    pend_p_d = pend_p_q;
    pend_m_d = pend_m_q;
    fail_d   = fail_q;
    afl_d    = afl_q;
    ovf_d    = ovf_q;

    if (strobe) begin
      seen_p_d = 1'b0;
      seen_m_d = 1'b0;
      nop_d    = ~win_p;
      nom_d    = ~win_m;
      both_d   = win_p & win_m;
      miss_d   = ~win_p & ~win_m;
      if (win_p ^ win_m)
        fail_d = 4'd0;
      else if (fail_q != 4'hF)
        fail_d = fail_q + 4'd1;
      if (fail_d == FAIL_LIM)
        afl_d = 1'b1;
    end

    case ({enq_p, ack_p})
      2'b10: if (pend_p_q == PEND_MAX) ovf_d = 1'b1; else pend_p_d = pend_p_q + PEND_ONE;
      2'b01: pend_p_d = pend_p_q - PEND_ONE;
      default: ;
    endcase
    case ({enq_m, ack_m})
      2'b10: if (pend_m_q == PEND_MAX) ovf_d = 1'b1; else pend_m_d = pend_m_q + PEND_ONE;
      2'b01: pend_m_d = pend_m_q - PEND_ONE;
      default: ;
    endcase

    if (bus.CCH33) begin
      afl_d  = 1'b0;
      ovf_d  = 1'b0;
      fail_d = 4'd0;
    end
    if (bus.GOJAM) begin
      seen_p_d = 1'b0;
      seen_m_d = 1'b0;
      pend_p_d = '0;
      pend_m_d = '0;
      fail_d   = 4'd0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      p_s1_q   <= 1'b0;
      p_s2_q   <= 1'b0;
      p_prev_q <= 1'b0;
      m_s1_q   <= 1'b0;
      m_s2_q   <= 1'b0;
      m_prev_q <= 1'b0;
      seen_p_q <= 1'b0;
      seen_m_q <= 1'b0;
      nop_q    <= 1'b0;
      nom_q    <= 1'b0;
      both_q   <= 1'b0;
      miss_q   <= 1'b0;
      pend_p_q <= '0;
      pend_m_q <= '0;
      fail_q   <= 4'd0;
      afl_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      p_s1_q   <= bus.PIPGp;
      p_s2_q   <= p_s1_q;
      p_prev_q <= p_s2_q;
      m_s1_q   <= bus.PIPGm;
      m_s2_q   <= m_s1_q;
      m_prev_q <= m_s2_q;
      seen_p_q <= seen_p_d;
      seen_m_q <= seen_m_d;
      nop_q    <= nop_d;
      nom_q    <= nom_d;
      both_q   <= both_d;
      miss_q   <= miss_d;
      pend_p_q <= pend_p_d;
      pend_m_q <= pend_m_d;
      fail_q   <= fail_d;
      afl_q    <= afl_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.PIPP   = (pend_p_q != '0);
  assign bus.PIPM   = (pend_m_q != '0) & (pend_p_q == '0);
  assign bus.NOP    = nop_q;
  assign bus.NOM    = nom_q;
  assign bus.BOTH   = both_q;
  assign bus.MISS   = miss_q;
  assign bus.PIPAFL = afl_q;
  assign bus.PIPOVF = ovf_q;

endmodule

// File: tb/tb_pipa_axis_sync.sv
// Directed bench for pipa_axis_sync; outputs compared as one vector
// {PIPP,PIPM,NOP,NOM,BOTH,MISS,PIPAFL,PIPOVF}.
module tb_pipa_axis_sync;
  logic CLOCK = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipa_axis_sync_if bus ();

  pipa_axis_sync #(.FAIL_LIMIT(4), .PEND_W(2)) dut (
    .CLOCK (CLOCK),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [7:0] outs();
    return {bus.PIPP, bus.PIPM, bus.NOP, bus.NOM, bus.BOTH, bus.MISS, bus.PIPAFL, bus.PIPOVF};
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // pulse raw inputs, wait for the synchroniser, then close the window
  task automatic window(input logic p, input logic m, input logic ack);
    bus.PIPGp = p;
    bus.PIPGm = m;
    tick();
    bus.PIPGp = 1'b0;
    bus.PIPGm = 1'b0;
    tick();
    bus.F5ASB2 = 1'b1;
    bus.CNTACK = ack;
    tick();
    bus.F5ASB2 = 1'b0;
    bus.CNTACK = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.CNTACK = 1'b1;
    tick();
    bus.CNTACK = 1'b0;
  endtask

  task automatic pulse_cch();
    bus.CCH33 = 1'b1;
    tick();
    bus.CCH33 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (outs() !== 8'b0000_0000) begin
      errors++;
      $display("FAIL reset outs=%b exp=%b", outs(), 8'b0000_0000);
    end
  endtask

  task automatic test_plus();
    window(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs() !== 8'b1001_0000) begin
      errors++;
      $display("FAIL plus_window outs=%b exp=%b", outs(), 8'b1001_0000);
    end
    pulse_ack();
    checks++;
    if (outs() !== 8'b0001_0000) begin
      errors++;
      $display("FAIL plus_ack outs=%b exp=%b", outs(), 8'b0001_0000);
    end
  endtask

  task automatic test_both();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      window(1'b1, 1'b1, 1'b0);
      exp = (i == 3) ? 8'b0000_1010 : 8'b0000_1000;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL both_window%0d outs=%b exp=%b", i, outs(), exp);
      end
    end
    window(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs() !== 8'b1001_0010) begin
      errors++;
      $display("FAIL both_good_sticky outs=%b exp=%b", outs(), 8'b1001_0010);
    end
    pulse_ack();
    pulse_cch();
    checks++;
    if (outs() !== 8'b0001_0000) begin
      errors++;
      $display("FAIL both_cch33 outs=%b exp=%b", outs(), 8'b0001_0000);
    end
  endtask

  task automatic test_miss();
    for (int i = 0; i < 3; i++) begin
      window(1'b0, 1'b0, 1'b0);
      checks++;
      if (outs() !== 8'b0011_0100) begin
        errors++;
        $display("FAIL miss_window%0d outs=%b exp=%b", i, outs(), 8'b0011_0100);
      end
    end
    window(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs() !== 8'b1001_0000) begin
      errors++;
      $display("FAIL miss_recover outs=%b exp=%b", outs(), 8'b1001_0000);
    end
    pulse_ack();
    // fail count restarted: three more bad windows must stay below the limit
    for (int i = 0; i < 3; i++) window(1'b1, 1'b1, 1'b0);
    checks++;
    if (outs() !== 8'b0000_1000) begin
      errors++;
      $display("FAIL miss_count_cleared outs=%b exp=%b", outs(), 8'b0000_1000);
    end
    window(1'b1, 1'b1, 1'b0);
    checks++;
    if (outs() !== 8'b0000_1010) begin
      errors++;
      $display("FAIL miss_fourth_bad outs=%b exp=%b", outs(), 8'b0000_1010);
    end
    pulse_cch();
    checks++;
    if (outs() !== 8'b0000_1000) begin
      errors++;
      $display("FAIL miss_cch33 outs=%b exp=%b", outs(), 8'b0000_1000);
    end
  endtask

  task automatic test_priority();
    logic [7:0] exp_ack [3] = '{8'b1010_0000, 8'b0110_0000, 8'b0010_0000};
    window(1'b1, 1'b0, 1'b0);
    window(1'b1, 1'b0, 1'b0);
    window(1'b0, 1'b1, 1'b0);
    checks++;
    if (outs() !== 8'b1010_0000) begin
      errors++;
      $display("FAIL prio_queued outs=%b exp=%b", outs(), 8'b1010_0000);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_ack();
      checks++;
      if (outs() !== exp_ack[i]) begin
        errors++;
        $display("FAIL prio_ack%0d outs=%b exp=%b", i, outs(), exp_ack[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    logic [7:0] exp_drain [3] = '{8'b1001_0000, 8'b1001_0000, 8'b0001_0000};
    for (int i = 0; i < 4; i++) begin
      window(1'b1, 1'b0, 1'b0);
      exp = (i == 3) ? 8'b1001_0001 : 8'b1001_0000;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL ovf_fill%0d outs=%b exp=%b", i, outs(), exp);
      end
    end
    pulse_cch();
    window(1'b1, 1'b0, 1'b1);
    checks++;
    if (outs() !== 8'b1001_0000) begin
      errors++;
      $display("FAIL ovf_enq_with_ack outs=%b exp=%b", outs(), 8'b1001_0000);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_ack();
      checks++;
      if (outs() !== exp_drain[i]) begin
        errors++;
        $display("FAIL ovf_drain%0d outs=%b exp=%b", i, outs(), exp_drain[i]);
      end
    end
  endtask

  task automatic test_gojam();
    window(1'b1, 1'b0, 1'b0);
    window(1'b1, 1'b0, 1'b0);
    window(1'b0, 1'b0, 1'b0);
    checks++;
    if (outs() !== 8'b1011_0100) begin
      errors++;
      $display("FAIL gojam_pre outs=%b exp=%b", outs(), 8'b1011_0100);
    end
    bus.GOJAM = 1'b1;
    tick();
    bus.GOJAM = 1'b0;
    checks++;
    if (outs() !== 8'b0011_0100) begin
      errors++;
      $display("FAIL gojam_clear outs=%b exp=%b", outs(), 8'b0011_0100);
    end
    // the miss before GOJAM must not count toward the fail limit
    for (int i = 0; i < 3; i++) window(1'b1, 1'b1, 1'b0);
    checks++;
    if (outs() !== 8'b0000_1000) begin
      errors++;
      $display("FAIL gojam_fail_cleared outs=%b exp=%b", outs(), 8'b0000_1000);
    end
    window(1'b1, 1'b0, 1'b0);
    pulse_ack();
  endtask

  task automatic test_reset_mid();
    window(1'b1, 1'b0, 1'b0);
    bus.PIPGm = 1'b1;
    tick();
    bus.PIPGm = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (outs() !== 8'b0000_0000) begin
      errors++;
      $display("FAIL rst_mid outs=%b exp=%b", outs(), 8'b0000_0000);
    end
    window(1'b1, 1'b0, 1'b0);
    checks++;
    if (outs() !== 8'b1001_0000) begin
      errors++;
      $display("FAIL rst_next_window outs=%b exp=%b", outs(), 8'b1001_0000);
    end
    pulse_ack();
    checks++;
    if (outs() !== 8'b0001_0000) begin
      errors++;
      $display("FAIL rst_drain outs=%b exp=%b", outs(), 8'b0001_0000);
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.PIPGp  = 1'b0;
    bus.PIPGm  = 1'b0;
    bus.F5ASB2 = 1'b0;
    bus.CNTACK = 1'b0;
    bus.GOJAM  = 1'b0;
    bus.CCH33  = 1'b0;
    test_reset();
    test_plus();
    test_both();
    test_miss();
    test_priority();
    test_overflow();
    test_gojam();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
